// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_pkg
// Brief   : Elaboration-time helpers for the sequence detector's transition table.
// Revision: 1.0
// ============================================================================
package fsm_seq_pkg;

    localparam int c_max_pattern_w = 32;

    // Bits needed to encode states S_0..S_n.
    function automatic int state_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Length of the longest proper prefix of the pattern that is also its suffix.
    // Pattern bit i (0 = first received) lives at pat[pw-1-i].
    function automatic int calc_fail_len(input logic [31:0] pat, input int pw);
        int f;
        bit ok;
        f = 0;
        for (int len = pw - 1; len >= 1; len--) begin
            if (f == 0) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++) begin
                    if (pat[pw-1-j] != pat[len-1-j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    f = len;
                end
            end
        end
        return f;
    endfunction

    // Next state from S_k on consuming bit b: longest pattern prefix that is a
    // suffix of (matched prefix, b). S_pw first falls back to S_f or S_0.
    function automatic int calc_next_state(input logic [31:0] pat, input int pw,
                                           input bit overlap, input int k, input int b);
        int          start;
        int          nxt;
        bit          ok;
        logic [32:0] seq;
        if (k > pw) begin
            return 0;
        end
        if (k == pw) begin
            start = overlap ? calc_fail_len(pat, pw) : 0;
        end else begin
            start = k;
        end
        seq = '0;
        for (int i = 0; i < start; i++) begin
            seq[i] = pat[pw-1-i];
        end
        seq[start] = (b != 0);
        nxt = 0;
        for (int len = start + 1; len >= 1; len--) begin
            if (nxt == 0) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++) begin
                    if (seq[start+1-len+j] != pat[pw-1-j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    nxt = len;
                end
            end
        end
        return nxt;
    endfunction

endpackage : fsm_seq_pkg
`default_nettype wire

// File: rtl/fsm_match_counter.sv
`default_nettype none
// ============================================================================
// Module  : fsm_match_counter
// Brief   : Saturating up-counter with synchronous clear and async reset.
// Revision: 1.0
// ============================================================================
module fsm_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : fsm_match_counter
`default_nettype wire

// File: rtl/fsm_seq_detect.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_detect
// Brief   : Moore detector for a fixed PATTERN_W-bit pattern on a qualified
//           serial stream, with overlap mode, clear and match counter.
// Revision: 1.0
// ============================================================================
module fsm_seq_detect
    import fsm_seq_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                 c_state_w   = state_width(PATTERN_W);
    localparam int                 c_n_states  = 1 << c_state_w;
    localparam int                 c_tbl_depth = 2 * c_n_states;
    localparam logic [31:0]        c_pat       = 32'(PATTERN);
    localparam logic [c_state_w-1:0] c_s_0     = '0;
    localparam logic [c_state_w-1:0] c_s_n     = c_state_w'(PATTERN_W);

    if ((PATTERN_W < 1) || (PATTERN_W > c_max_pattern_w)) begin : g_bad_pattern_w
        $error("fsm_seq_detect: PATTERN_W out of range 1..32");
    end
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("fsm_seq_detect: CNT_W out of range 1..32");
    end

    // Transition table indexed by {state, din}; encodings above S_N are unreachable.
    logic [c_state_w-1:0] w_next_tbl [c_tbl_depth];

    for (genvar s = 0; s < c_n_states; s++) begin : g_tbl_state
        for (genvar b = 0; b < 2; b++) begin : g_tbl_bit
            if (s <= PATTERN_W) begin : g_live
                localparam int c_nxt = calc_next_state(c_pat, PATTERN_W, OVERLAP, s, b);
                assign w_next_tbl[2*s+b] = c_state_w'(c_nxt);
            end else begin : g_unused
                assign w_next_tbl[2*s+b] = c_s_0;
            end
        end
    end

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 w_inc;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= c_s_0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // din is only looked at on valid edges so idle X never reaches the state.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        if (clear) begin
            w_state_nxt = c_s_0;
        end else if (din_valid) begin
            w_state_nxt = w_next_tbl[{r_state, din}];
            w_inc       = (w_state_nxt == c_s_n);
        end
    end

    assign dout = (r_state == c_s_n);

    fsm_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk     (clk),
        .areset  (areset),
        .i_inc   (w_inc),
        .i_clr   (clear),
        .o_count (match_cnt)
    );

endmodule : fsm_seq_detect
`default_nettype wire

// File: tb/tb_fsm_seq_detect.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsm_seq_detect
// Brief   : Self-checking bench; four detector configurations share one stream.
// Revision: 1.0
// ============================================================================
module tb_fsm_seq_detect;

    logic clk = 1'b0;
    logic areset;
    logic din;
    logic din_valid;
    logic clear;

    logic       dout_ov,  dout_no,  dout_sat, dout_p1;
    logic [7:0] cnt_ov,   cnt_no,   cnt_p1;
    logic [1:0] cnt_sat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_seq_detect #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout_ov), .match_cnt(cnt_ov));
    fsm_seq_detect #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout_no), .match_cnt(cnt_no));
    fsm_seq_detect #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout_sat), .match_cnt(cnt_sat));
    fsm_seq_detect #(.PATTERN_W(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_p1 (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout_p1), .match_cnt(cnt_p1));

    wire [29:0] obs = {dout_ov, cnt_ov, dout_no, cnt_no, dout_sat, cnt_sat, dout_p1, cnt_p1};

    // Reference: remember recent bits and look for the pattern in them;
    // the non-overlapping detector forgets its history after each hit.
    logic [3:0] m_hist_ov, m_hist_no;
    int         m_len_ov,  m_len_no;
    logic       m_dout_ov, m_dout_no, m_dout_p1;
    int         m_cnt_ov,  m_cnt_no,  m_cnt_sat, m_cnt_p1;

    task automatic model_reset();
        m_hist_ov = '0; m_hist_no = '0; m_len_ov = 0; m_len_no = 0;
        m_dout_ov = 1'b0; m_dout_no = 1'b0; m_dout_p1 = 1'b0;
        m_cnt_ov = 0; m_cnt_no = 0; m_cnt_sat = 0; m_cnt_p1 = 0;
    endtask

    task automatic model_step(input logic d, input logic v, input logic c);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_hist_ov = {m_hist_ov[2:0], d};
            if (m_len_ov < 4) m_len_ov++;
            m_dout_ov = (m_len_ov == 4) && (m_hist_ov == 4'b1011);
            if (m_dout_ov && m_cnt_ov < 255) m_cnt_ov++;

            m_hist_no = {m_hist_no[2:0], d};
            if (m_len_no < 4) m_len_no++;
            m_dout_no = (m_len_no == 4) && (m_hist_no == 4'b1011);
            if (m_dout_no) begin
                m_len_no = 0;
                if (m_cnt_no < 255) m_cnt_no++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end

            m_dout_p1 = (d == 1'b1);
            if (m_dout_p1 && m_cnt_p1 < 255) m_cnt_p1++;
        end
    endtask

    function automatic logic [29:0] model_vec();
        return {m_dout_ov, 8'(m_cnt_ov), m_dout_no, 8'(m_cnt_no),
                m_dout_no, 2'(m_cnt_sat), m_dout_p1, 8'(m_cnt_p1)};
    endfunction

    task automatic cycle(input logic d, input logic v, input logic c);
        din = d; din_valid = v; clear = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] bits = 4'b1011;
        areset = 1'b1; din = 1'b1; din_valid = 1'b1; clear = 1'b0;
        model_reset();
        #2;
        n_tests++;
        if (obs !== 30'd0) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", obs, 30'd0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (obs !== 30'd0) begin
            n_fail++; $display("FAIL reset_hold_edge: got %h expected %h", obs, 30'd0);
        end
        @(negedge clk); areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL reset_pre_ones[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        @(negedge clk); areset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (obs !== 30'd0) begin
            n_fail++; $display("FAIL reset_async_pulse: got %h expected %h", obs, 30'd0);
        end
        #2; areset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cycle(bits[i], 1'b1, 1'b0);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL reset_post_bit[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        n_tests++;
        if (dout_ov !== 1'b1 || cnt_ov !== 8'd1) begin
            n_fail++; $display("FAIL reset_first_match: got dout=%b cnt=%0d expected dout=1 cnt=1", dout_ov, cnt_ov);
        end
    endtask

    task automatic test_basic();
        logic [4:0] bits = 5'b10110;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            cycle(bits[i], 1'b1, 1'b0);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL basic_bit[%0d]: got %h expected %h", i, obs, model_vec());
            end
            if (i == 1) begin
                n_tests++;
                if (dout_ov !== 1'b1 || cnt_ov !== 8'd1) begin
                    n_fail++; $display("FAIL basic_match: got dout=%b cnt=%0d expected dout=1 cnt=1", dout_ov, cnt_ov);
                end
            end
        end
        n_tests++;
        if (dout_ov !== 1'b0) begin
            n_fail++; $display("FAIL basic_drop: got dout=%b expected 0", dout_ov);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            cycle(bits[i], 1'b1, 1'b0);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL overlap_bit[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        n_tests++;
        if (cnt_ov !== 8'd2 || dout_ov !== 1'b1 || cnt_no !== 8'd1 || dout_no !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_counts: got ov=%0d/%b no=%0d/%b expected ov=2/1 no=1/0",
                     cnt_ov, dout_ov, cnt_no, dout_no);
        end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] bits = 4'b1011;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            cycle(bits[i], 1'b1, 1'b0);
            for (int g = 0; g < 4; g++) begin
                n_tests++;
                if (obs !== model_vec()) begin
                    n_fail++; $display("FAIL gaps_bit[%0d] idle %0d: got %h expected %h", i, g, obs, model_vec());
                end
                if (g < 3) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        n_tests++;
        if (cnt_ov !== 8'd1 || dout_ov !== 1'b1) begin
            n_fail++; $display("FAIL gaps_hold: got dout=%b cnt=%0d expected dout=1 cnt=1", dout_ov, cnt_ov);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] bits = 4'b1011;
        int         exp_sat;
        cycle(1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0);
            exp_sat = (r + 1 > 3) ? 3 : r + 1;
            n_tests++;
            if (cnt_sat !== 2'(exp_sat) || obs !== model_vec()) begin
                n_fail++; $display("FAIL saturation[%0d]: got cnt=%0d vec=%h expected cnt=%0d vec=%h",
                                   r, cnt_sat, obs, exp_sat, model_vec());
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [3:0] bits = 4'b1011;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs !== 30'd0) begin
            n_fail++; $display("FAIL clear_priority: got %h expected %h", obs, 30'd0);
        end
        for (int i = 3; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0);
        n_tests++;
        if (cnt_ov !== 8'd1 || cnt_no !== 8'd1 || dout_ov !== 1'b1) begin
            n_fail++; $display("FAIL clear_rematch: got ov=%0d no=%0d dout=%b expected 1 1 1", cnt_ov, cnt_no, dout_ov);
        end
    endtask

    task automatic test_random();
        logic d, v, c;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            d = 1'($urandom_range(0, 1));
            if (!v && $urandom_range(0, 1) == 0) d = 1'bx;
            cycle(d, v, c);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gaps();
        test_saturation();
        test_clear_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fsm_seq_detect
`default_nettype wire

// File: doc/fsm_seq_detect.md
Name: fsm_seq_detect

Overview:
Parametrised Moore sequence detector. It is the next generation of the team's two-state single-bit Moore FSM, generalised to a programmable PATTERN_W-bit pattern. It adds an input-valid qualifier, a selectable overlap mode, a synchronous clear and a saturating match counter. It sits on a serial bit stream, flags pattern occurrences and counts them for status readout.

Parameters:
PATTERN_W, 4, pattern length in bits; legal range 1..32
PATTERN, 4'b1011, pattern bits; PATTERN[PATTERN_W-1] is the first bit received
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after a match
CNT_W, 8, match counter width; legal range 1..32

Ports:
clk  input  1  clock; all state updates on the rising edge
areset  input  1  reset, asynchronous, active-high
din  input  1  serial data bit
din_valid  input  1  din is consumed on this edge only when high
clear  input  1  synchronous clear of state and counter
dout  output  1  Moore match flag; high while FSM is in state S_N
match_cnt  output  CNT_W  number of matches since reset/clear, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is areset.
- States S_0..S_N, where N = PATTERN_W. S_k means the last k consumed bits equal the first k pattern bits, and k is maximal.
- State register width: clog2(N+1).
- Reset (areset high): state = S_0, dout = 0, match_cnt = 0, effective immediately without waiting for a clock edge.
- Reset values hold while areset is high. Deassertion takes effect at the next edge, which then behaves normally.
- Edge priority: areset > clear > din_valid.
- clear = 1: state <= S_0 and match_cnt <= 0, regardless of din_valid.
- din_valid = 0 (and no clear): state and match_cnt hold. dout holds, including staying high in S_N.
- din_valid = 1, from S_k with k < N: next state is the longest prefix of PATTERN that is a suffix of (matched prefix k, din).
- din_valid = 1, from S_N with OVERLAP = 1: start from S_f, where f = length of the longest proper prefix of PATTERN that is also its suffix. Then apply din as above.
- din_valid = 1, from S_N with OVERLAP = 0: apply din as if from S_0.
- Next-state table is computed at elaboration as a constant (KMP-style). No runtime pattern storage.
- dout = (state == S_N), decoded from the state register. dout is high for exactly the cycle(s) after the edge that consumed the last pattern bit.
- Latency: 1 clock from the last bit's valid edge to dout = 1.
- match_cnt increments by 1 on every edge where next state is S_N and din_valid = 1.
- match_cnt saturates at 2^CNT_W-1 and never wraps.
- PATTERN_W = 1: states S_0/S_1; dout follows (din == PATTERN) one cycle late on valid edges, in both modes.
- No X on outputs after reset, including when inputs are X while din_valid = 0.

Decomposition:
- Package fsm_seq_pkg:
  - function computing the next-state table from PATTERN/PATTERN_W/OVERLAP
  - function computing the failure length f
  - function computing state width (clog2)
- Sub-module fsm_match_counter (CNT_W): saturating counter with inc, clr and asynchronous reset.
- Top level holds the state register and the table lookup.

Test Plan (PATTERN = 4'b1011, PATTERN_W = 4 unless stated):
- Reset: drive din = 1, valid = 1 for 3 cycles, then pulse areset mid-cycle at the negedge -> dout = 0 and match_cnt = 0 before the next posedge. First match after release needs a full 1,0,1,1.
- Basic: valid every cycle, din 1,0,1,1 -> dout = 1 one cycle after the 4th edge, match_cnt = 1. Next din 0 -> dout = 0.
- Overlap: din 1,0,1,1,0,1,1 -> OVERLAP = 1 gives match_cnt = 2 with dout high after the 4th and 7th bits. OVERLAP = 0 gives match_cnt = 1.
- Valid gaps: same 1,0,1,1 with 3 idle (valid = 0) cycles after each bit and din toggling randomly while idle -> match_cnt = 1. dout stays high through the idle cycles after the match.
- Saturation: CNT_W = 2, stream 1011 five times with OVERLAP = 0 -> match_cnt reads 1,2,3,3,3.
- Clear priority: in S_3 (after 1,0,1), assert clear with valid = 1 and din = 1 on the same edge -> state S_0, dout = 0, match_cnt = 0. A following 1,0,1,1 yields match_cnt = 1.
